// File: rtl/mem_req_arbiter.sv
// Single-outstanding memory request scheduler: three requester slots (inst read,
// data read, data write) feeding one downstream req/rsp port, with inst
// anti-starvation, response routing and a per-transaction abort timeout.

// One request slot: a pulse loads the payload and sets pending; grant clears it.
// A load in the same cycle as a clear wins, so the new request stays queued.
module mem_req_slot #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         clr_i,
  input  logic [W-1:0] din_i,
  output logic         pend_o,
  output logic [W-1:0] dout_o
);
  logic         pend_q;
  logic [W-1:0] data_q;

  // pending flag and payload (latest request wins)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= 1'b0;
      data_q <= '0;
    end else if (load_i) begin
      pend_q <= 1'b1;
      data_q <= din_i;
    end else if (clr_i) begin
      pend_q <= 1'b0;
    end
  end

  assign pend_o = pend_q;
  assign dout_o = data_q;
endmodule

module mem_req_arbiter #(
  parameter int unsigned STARVE_MAX  = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        inst_rden_i,
  input  logic [31:0] inst_riaddr_i,
  output logic [31:0] inst_roaddr_o,
  output logic        inst_rvalid_o,
  output logic [31:0] inst_rdata_o,
  input  logic        data_rden_i,
  input  logic [31:0] data_riaddr_i,
  output logic [31:0] data_roaddr_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  input  logic        data_wren_i,
  input  logic [3:0]  data_wstrb_i,
  input  logic [31:0] data_waddr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_wdone_o,
  output logic        mem_wait_o,
  output logic        req_valid_o,
  input  logic        req_ready_i,
  output logic        req_we_o,
  output logic [31:0] req_addr_o,
  output logic [3:0]  req_wstrb_o,
  output logic [31:0] req_wdata_o,
  input  logic        rsp_valid_i,
  input  logic [31:0] rsp_data_i,
  output logic        err_o
);
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam bit TMO_EN = (TIMEOUT_CYC > 0);

  localparam logic [1:0] SRC_INST = 2'd0;
  localparam logic [1:0] SRC_DR   = 2'd1;
  localparam logic [1:0] SRC_WR   = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  typedef struct packed {
    logic [1:0]  src;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } iss_t;

  state_t         state_q, state_d;
  iss_t           iss_q, iss_d;
  logic [SW-1:0]  starve_q, starve_d;
  logic [TW-1:0]  tmo_q, tmo_d;

  logic        inst_pend, dr_pend, wr_pend, any_pend;
  logic [31:0] inst_addr, dr_addr;
  logic [67:0] wr_slot;
  logic        grant;
  logic [1:0]  gsrc;
  logic        tmo_hit, rsp_take, abort, done;
  logic [31:0] rsp_word;

  logic        inst_rvalid_q, data_rvalid_q, data_wdone_q, err_q;
  logic [31:0] inst_roaddr_q, inst_rdata_q, data_roaddr_q, data_rdata_q;

  mem_req_slot #(.W(32)) u_inst_slot (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (inst_rden_i),
    .clr_i  (grant && gsrc == SRC_INST),
    .din_i  (inst_riaddr_i),
    .pend_o (inst_pend),
    .dout_o (inst_addr)
  );

  mem_req_slot #(.W(32)) u_dr_slot (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (data_rden_i),
    .clr_i  (grant && gsrc == SRC_DR),
    .din_i  (data_riaddr_i),
    .pend_o (dr_pend),
    .dout_o (dr_addr)
  );

  mem_req_slot #(.W(68)) u_wr_slot (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (data_wren_i),
    .clr_i  (grant && gsrc == SRC_WR),
    .din_i  ({data_wstrb_i, data_wdata_i, data_waddr_i}),
    .pend_o (wr_pend),
    .dout_o (wr_slot)
  );

  assign any_pend = inst_pend | dr_pend | wr_pend;
  assign grant    = (state_q == S_IDLE) && any_pend;

  // priority pick: write > dread > inst, unless inst has been starved too long
  always_comb begin
    gsrc = SRC_INST;
    if (inst_pend && starve_q == STARVE_TOP) gsrc = SRC_INST;
    else if (wr_pend)                        gsrc = SRC_WR;
    else if (dr_pend)                        gsrc = SRC_DR;
  end

  // starve counter: counts data grants that jumped ahead of a waiting inst
  always_comb begin
    starve_d = starve_q;
    if (!inst_pend) begin
      starve_d = '0;
    end else if (grant) begin
      if (gsrc == SRC_INST)            starve_d = '0;
      else if (starve_q != STARVE_TOP) starve_d = starve_q + SW'(1);
    end
  end

  // issue register: captured at grant, drives REQ_* while the transaction runs
  always_comb begin
    iss_d = iss_q;
    if (grant) begin
      iss_d.src   = gsrc;
      iss_d.we    = 1'b0;
      iss_d.strb  = '0;
      iss_d.wdata = '0;
      case (gsrc)
        SRC_WR: begin
          iss_d.we    = 1'b1;
          iss_d.addr  = wr_slot[31:0];
          iss_d.wdata = wr_slot[63:32];
          iss_d.strb  = wr_slot[67:64];
        end
        SRC_DR:  iss_d.addr = dr_addr;
        default: iss_d.addr = inst_addr;
      endcase
    end
  end

  // timeout: counts cycles spent in ISSUE/WAIT, cleared whenever idle
  assign tmo_d    = (state_q == S_IDLE || !TMO_EN) ? '0 : tmo_q + TW'(1);
  assign tmo_hit  = TMO_EN && (state_q != S_IDLE) && (tmo_q == TMO_LAST);
  assign rsp_take = (state_q == S_WAIT) && rsp_valid_i;
  assign abort    = tmo_hit && !rsp_take;
  assign done     = rsp_take || abort;
  assign rsp_word = rsp_take ? rsp_data_i : 32'h0;

  // state, issue, starve and timeout registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      iss_q    <= '0;
      starve_q <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      iss_q    <= iss_d;
      starve_q <= starve_d;
      tmo_q    <= tmo_d;
    end
  end

  // next state: a real response beats a same-cycle timeout in WAIT
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (grant) state_d = S_ISSUE;
      S_ISSUE: begin
        if (tmo_hit)          state_d = S_IDLE;
        else if (req_ready_i) state_d = S_WAIT;
      end
      S_WAIT:  if (rsp_take || tmo_hit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM-derived outputs
  always_comb begin
    req_valid_o = (state_q == S_ISSUE);
    mem_wait_o  = any_pend || (state_q != S_IDLE);
  end

  // completion routing: one pulse to the originator, data/addr held between pulses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inst_rvalid_q <= 1'b0;
      data_rvalid_q <= 1'b0;
      data_wdone_q  <= 1'b0;
      err_q         <= 1'b0;
      inst_roaddr_q <= '0;
      inst_rdata_q  <= '0;
      data_roaddr_q <= '0;
      data_rdata_q  <= '0;
    end else begin
      inst_rvalid_q <= 1'b0;
      data_rvalid_q <= 1'b0;
      data_wdone_q  <= 1'b0;
      err_q         <= abort;
      if (done) begin
        case (iss_q.src)
          SRC_WR: data_wdone_q <= 1'b1;
          SRC_DR: begin
            data_rvalid_q <= 1'b1;
            data_roaddr_q <= iss_q.addr;
            data_rdata_q  <= rsp_word;
          end
          default: begin
            inst_rvalid_q <= 1'b1;
            inst_roaddr_q <= iss_q.addr;
            inst_rdata_q  <= rsp_word;
          end
        endcase
      end
    end
  end

  assign req_we_o      = iss_q.we;
  assign req_addr_o    = iss_q.addr;
  assign req_wstrb_o   = iss_q.strb;
  assign req_wdata_o   = iss_q.wdata;
  assign inst_rvalid_o = inst_rvalid_q;
  assign inst_roaddr_o = inst_roaddr_q;
  assign inst_rdata_o  = inst_rdata_q;
  assign data_rvalid_o = data_rvalid_q;
  assign data_roaddr_o = data_roaddr_q;
  assign data_rdata_o  = data_rdata_q;
  assign data_wdone_o  = data_wdone_q;
  assign err_o         = err_q;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: single-request vector table plus
// hand-written sequences for ordering, starvation, stall, timeout, overwrite, reset.
module tb_mem_req_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_rden, data_rden, data_wren;
  logic [31:0] inst_riaddr, data_riaddr, data_waddr, data_wdata;
  logic [3:0]  data_wstrb;
  logic [31:0] inst_roaddr, inst_rdata, data_roaddr, data_rdata;
  logic        inst_rvalid, data_rvalid, data_wdone, mem_wait, err;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  mem_req_arbiter #(.STARVE_MAX(4), .TIMEOUT_CYC(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .inst_rden_i(inst_rden), .inst_riaddr_i(inst_riaddr), .inst_roaddr_o(inst_roaddr),
    .inst_rvalid_o(inst_rvalid), .inst_rdata_o(inst_rdata),
    .data_rden_i(data_rden), .data_riaddr_i(data_riaddr), .data_roaddr_o(data_roaddr),
    .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata),
    .data_wren_i(data_wren), .data_wstrb_i(data_wstrb), .data_waddr_i(data_waddr),
    .data_wdata_i(data_wdata), .data_wdone_o(data_wdone), .mem_wait_o(mem_wait),
    .req_valid_o(req_valid), .req_ready_i(req_ready), .req_we_o(req_we),
    .req_addr_o(req_addr), .req_wstrb_o(req_wstrb), .req_wdata_o(req_wdata),
    .rsp_valid_i(rsp_valid), .rsp_data_i(rsp_data), .err_o(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int kind; logic [31:0] addr; logic [31:0] data; logic err; int cyc; } cpl_t;
  typedef struct { logic we; logic [31:0] addr; logic [3:0] strb; logic [31:0] wdata; } iss_t;
  cpl_t cpl_q[$];
  iss_t iss_q[$];

  int n_cmp = 0, n_bad = 0, err_cnt = 0, ready_lo = 0;
  bit rsp_en = 1, use_fixed = 0, late_rsp = 0, hs_prev = 0;
  logic [31:0] fixed_word = 32'h0, hs_addr = 32'h0;

  // Monitor + slave model: response arrives the cycle after the handshake,
  // data = address ^ 5A5A0000 unless a fixed word is selected.
  always @(negedge clk) begin
    if (inst_rvalid) cpl_q.push_back('{0, inst_roaddr, inst_rdata, err, cyc});
    if (data_rvalid) cpl_q.push_back('{1, data_roaddr, data_rdata, err, cyc});
    if (data_wdone)  cpl_q.push_back('{2, 32'h0, 32'h0, err, cyc});
    if (err) err_cnt++;
    rsp_valid = (hs_prev && rsp_en) || late_rsp;
    rsp_data  = use_fixed ? fixed_word : (hs_addr ^ 32'h5A5A_0000);
    if (req_valid && ready_lo > 0) begin
      req_ready = 1'b0;
      ready_lo--;
    end else begin
      req_ready = 1'b1;
    end
    hs_prev = req_valid && req_ready;
    if (hs_prev) begin
      hs_addr = req_addr;
      iss_q.push_back('{req_we, req_addr, req_wstrb, req_wdata});
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // one-cycle request pulse; pc returns the cycle of the pulse
  task automatic req(input int kind, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] st, output int pc);
    case (kind)
      0: begin inst_rden = 1'b1; inst_riaddr = a; end
      1: begin data_rden = 1'b1; data_riaddr = a; end
      default: begin data_wren = 1'b1; data_waddr = a; data_wdata = wd; data_wstrb = st; end
    endcase
    pc = cyc;
    tick();
    inst_rden = 1'b0; data_rden = 1'b0; data_wren = 1'b0;
  endtask

  task automatic wait_cpl(input int n);
    int k = 0;
    while (cpl_q.size() < n && k < 300) begin tick(); k++; end
    chk("cpl_count", cpl_q.size(), n);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, {inst_rvalid, data_rvalid, data_wdone, mem_wait, err, req_valid, req_we, req_wstrb}, 64'h0);
    chk({nm, "_dat"}, {inst_roaddr | inst_rdata | data_roaddr | data_rdata, req_addr | req_wdata}, 64'h0);
  endtask

  typedef struct {
    int kind; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb;
    logic exp_we; logic [3:0] exp_strb; logic [31:0] exp_wdata; logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int pc;
    vecs[0] = '{0, 32'h0000_1000, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0, 32'h5A5A_1000};
    vecs[1] = '{1, 32'h0000_2004, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0, 32'h5A5A_2004};
    vecs[2] = '{2, 32'h0000_3008, 32'hCAFE_F00D, 4'hF, 1'b1, 4'hF, 32'hCAFE_F00D, 32'h0};
    vecs[3] = '{2, 32'h0000_400C, 32'h1234_5678, 4'h3, 1'b1, 4'h3, 32'h1234_5678, 32'h0};
    vecs[4] = '{1, 32'hFFFF_FFFC, 32'h0, 4'h0, 1'b0, 4'h0, 32'h0, 32'hA5A5_FFFC};

    rst_n = 1'b0; inst_rden = 0; data_rden = 0; data_wren = 0;
    inst_riaddr = 0; data_riaddr = 0; data_waddr = 0; data_wdata = 0; data_wstrb = 0;
    req_ready = 1'b1; rsp_valid = 1'b0; rsp_data = 0;
    repeat (3) tick();
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (2) tick();
    chk_zero("post_reset");

    // single requests: issue fields, completion routing, 4-cycle latency
    for (int i = 0; i < 5; i++) begin
      cpl_q.delete(); iss_q.delete();
      req(vecs[i].kind, vecs[i].addr, vecs[i].wdata, vecs[i].strb, pc);
      wait_cpl(1);
      tick();
      chk($sformatf("v%0d_iss_n", i), iss_q.size(), 1);
      if (iss_q.size() > 0) begin
        chk($sformatf("v%0d_we", i), iss_q[0].we, vecs[i].exp_we);
        chk($sformatf("v%0d_addr", i), iss_q[0].addr, vecs[i].addr);
        chk($sformatf("v%0d_strb", i), iss_q[0].strb, vecs[i].exp_strb);
        chk($sformatf("v%0d_wdata", i), iss_q[0].wdata, vecs[i].exp_wdata);
      end
      if (cpl_q.size() > 0) begin
        chk($sformatf("v%0d_kind", i), cpl_q[0].kind, vecs[i].kind);
        chk($sformatf("v%0d_lat", i), cpl_q[0].cyc - pc, 4);
        chk($sformatf("v%0d_err", i), cpl_q[0].err, 1'b0);
        if (vecs[i].kind != 2) begin
          chk($sformatf("v%0d_roaddr", i), cpl_q[0].addr, vecs[i].addr);
          chk($sformatf("v%0d_rdata", i), cpl_q[0].data, vecs[i].exp_rdata);
        end
      end
      chk($sformatf("v%0d_memwait", i), mem_wait, 1'b0);
    end
    chk("inst_hold", {inst_roaddr, inst_rdata}, {32'h0000_1000, 32'h5A5A_1000});

    // simultaneous requests: write, dread, inst order
    cpl_q.delete(); iss_q.delete();
    inst_rden = 1; inst_riaddr = 32'hA00;
    data_rden = 1; data_riaddr = 32'hB00;
    data_wren = 1; data_waddr = 32'hC00; data_wdata = 32'h1111_2222; data_wstrb = 4'hC;
    tick();
    inst_rden = 0; data_rden = 0; data_wren = 0;
    chk("sim_memwait", mem_wait, 1'b1);
    wait_cpl(3);
    tick();
    chk("sim_iss_n", iss_q.size(), 3);
    if (iss_q.size() == 3) begin
      chk("sim_iss0", {iss_q[0].we, iss_q[0].addr, iss_q[0].strb}, {1'b1, 32'hC00, 4'hC});
      chk("sim_iss1", {iss_q[1].we, iss_q[1].addr}, {1'b0, 32'hB00});
      chk("sim_iss2", {iss_q[2].we, iss_q[2].addr}, {1'b0, 32'hA00});
    end
    if (cpl_q.size() == 3) begin
      chk("sim_cpl", {cpl_q[0].kind[3:0], cpl_q[1].kind[3:0], cpl_q[2].kind[3:0]}, 12'h210);
      chk("sim_drdata", cpl_q[1].data, 32'h5A5A_0B00);
      chk("sim_irdata", cpl_q[2].data, 32'h5A5A_0A00);
    end

    // starvation: dread held busy, inst must win after exactly 4 data grants; twice
    for (int r = 0; r < 2; r++) begin
      int k = 0;
      cpl_q.delete(); iss_q.delete();
      inst_rden = 1; inst_riaddr = 32'h700;
      data_rden = 1; data_riaddr = 32'h800;
      tick();
      inst_rden = 0;
      while (iss_q.size() < 5 && k < 200) begin
        k++;
        data_riaddr = 32'h800 + 32'(k * 4);
        tick();
      end
      data_rden = 0;
      wait_cpl(6);
      tick();
      chk($sformatf("stv%0d_iss_n", r), iss_q.size(), 6);
      if (iss_q.size() == 6) begin
        for (int j = 0; j < 4; j++)
          chk($sformatf("stv%0d_d%0d", r, j), iss_q[j].addr[31:8], 24'h8);
        chk($sformatf("stv%0d_inst", r), iss_q[4].addr, 32'h700);
        chk($sformatf("stv%0d_last", r), iss_q[5].addr[31:8], 24'h8);
      end
      if (cpl_q.size() == 6) chk($sformatf("stv%0d_ikind", r), cpl_q[4].kind, 0);
    end

    // downstream stall: REQ_ADDR must hold while READY low for 10 cycles
    begin
      int vcyc = 0, k = 0;
      cpl_q.delete(); iss_q.delete();
      use_fixed = 1; fixed_word = 32'hDEAD_BEEF; ready_lo = 10;
      req(0, 32'h100, 32'h0, 4'h0, pc);
      while (cpl_q.size() == 0 && k < 100) begin
        tick(); k++;
        if (req_valid) begin
          vcyc++;
          chk("stall_addr", req_addr, 32'h100);
        end
      end
      chk("stall_valid_cycles", vcyc, 11);
      wait_cpl(1);
      chk("stall_out", {inst_roaddr, inst_rdata}, {32'h100, 32'hDEAD_BEEF});
      use_fixed = 0;
      tick();
    end

    // timeout on a data read, then a late response must be dropped
    begin
      int e0;
      cpl_q.delete(); iss_q.delete();
      e0 = err_cnt; rsp_en = 0;
      req(1, 32'h40, 32'h0, 4'h0, pc);
      wait_cpl(1);
      if (cpl_q.size() > 0) begin
        chk("tmo_kind", cpl_q[0].kind, 1);
        chk("tmo_err_with_rvalid", cpl_q[0].err, 1'b1);
        chk("tmo_rdata", cpl_q[0].data, 32'h0);
        chk("tmo_roaddr", cpl_q[0].addr, 32'h40);
        chk("tmo_latency", cpl_q[0].cyc - pc, 18);
      end
      tick();
      chk("tmo_reqvalid", req_valid, 1'b0);
      cpl_q.delete();
      late_rsp = 1; tick(); late_rsp = 0;
      repeat (5) tick();
      chk("late_rsp_cpl", cpl_q.size(), 0);
      chk("tmo_err_cnt", err_cnt - e0, 1);
      chk("late_memwait", mem_wait, 1'b0);
      rsp_en = 1;
    end

    // overwrite: two dread pulses while busy -> one read to the latest address
    cpl_q.delete(); iss_q.delete();
    ready_lo = 3;
    req(0, 32'h900, 32'h0, 4'h0, pc);
    tick();
    req(1, 32'h10, 32'h0, 4'h0, pc);
    req(1, 32'h20, 32'h0, 4'h0, pc);
    wait_cpl(2);
    tick();
    chk("ovw_iss_n", iss_q.size(), 2);
    if (iss_q.size() == 2) chk("ovw_addr", iss_q[1].addr, 32'h20);
    if (cpl_q.size() == 2)
      chk("ovw_cpl", {cpl_q[1].addr, cpl_q[1].data}, {32'h20, 32'h5A5A_0020});

    // async reset while waiting for a response
    begin
      int e0;
      cpl_q.delete(); iss_q.delete();
      e0 = err_cnt; rsp_en = 0;
      req(0, 32'h55, 32'h0, 4'h0, pc);
      tick(); tick();
      req(1, 32'h66, 32'h0, 4'h0, pc);
      chk("rst_pre_memwait", mem_wait, 1'b1);
      rst_n = 1'b0;
      #1;
      chk_zero("midrst");
      tick(); tick();
      rst_n = 1'b1; rsp_en = 1;
      repeat (20) tick();
      chk("midrst_cpl", cpl_q.size(), 0);
      chk("midrst_iss", iss_q.size(), 1);
      chk("midrst_err", err_cnt - e0, 0);
      chk("midrst_memwait", mem_wait, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
